// File: rtl/vending_pkg.sv
// Shared definitions for the micro vending machine: state encodings, coin values,
// button indices, pricing and seven-segment helpers.
package vending_pkg;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SELECT = 6'b000010,
    ST_PAY    = 6'b000100,
    ST_PAID   = 6'b001000,
    ST_CHANGE = 6'b010000,
    ST_REFUND = 6'b100000
  } state_t;

  localparam logic [7:0] COIN_ONE    = 8'd1;
  localparam logic [7:0] COIN_FIVE   = 8'd5;
  localparam logic [7:0] COIN_TEN    = 8'd10;
  localparam logic [7:0] COIN_TWENTY = 8'd20;
  localparam logic [7:0] COIN_FIFTY  = 8'd50;

  localparam int BTN_ONE     = 0;
  localparam int BTN_FIVE    = 1;
  localparam int BTN_TEN     = 2;
  localparam int BTN_TWENTY  = 3;
  localparam int BTN_FIFTY   = 4;
  localparam int BTN_GOODS   = 5;
  localparam int BTN_CONFIRM = 6;
  localparam int BTN_CHANGE  = 7;
  localparam int BTN_CANCEL  = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] item_cost(input logic [2:0] hi, input logic [2:0] lo,
                                           input logic [1:0] num);
    logic [3:0] unit_price;
    unit_price = {1'b0, hi} + {1'b0, lo};
    return {4'd0, unit_price} * {6'd0, num};
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; anything outside 0..9 blanks the digit
  function automatic logic [7:0] seg_digit(input logic [7:0] d);
    case (d)
      8'd0:    return 8'hC0;
      8'd1:    return 8'hF9;
      8'd2:    return 8'hA4;
      8'd3:    return 8'hB0;
      8'd4:    return 8'h99;
      8'd5:    return 8'h92;
      8'd6:    return 8'h82;
      8'd7:    return 8'hF8;
      8'd8:    return 8'h80;
      8'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [2:0] state_index(input state_t s);
    case (s)
      ST_IDLE:   return 3'd0;
      ST_SELECT: return 3'd1;
      ST_PAY:    return 3'd2;
      ST_PAID:   return 3'd3;
      ST_CHANGE: return 3'd4;
      ST_REFUND: return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner: need on the left, a context value
// in the middle, state index on the right; digit enables and segments registered.
module seg_scan import vending_pkg::*; #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] need,
  input  logic [7:0] mid_value,
  input  logic       mid_blank,
  input  logic [2:0] state_idx,
  output logic [7:0] bit_select,
  output logic [7:0] seg_select
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic [2:0]    digit_r;
  logic [7:0]    bit_select_r;
  logic [7:0]    seg_select_r;
  logic [7:0]    seg_s;

  // Digit mux with binary-to-decimal split; leading zeros are shown
  always_comb begin
    seg_s = SEG_BLANK;
    case (digit_r)
      3'd7:    seg_s = seg_digit(need / 8'd100);
      3'd6:    seg_s = seg_digit((need / 8'd10) % 8'd10);
      3'd5:    seg_s = seg_digit(need % 8'd10);
      3'd4:    seg_s = mid_blank ? SEG_BLANK : seg_digit(mid_value / 8'd100);
      3'd3:    seg_s = mid_blank ? SEG_BLANK : seg_digit((mid_value / 8'd10) % 8'd10);
      3'd2:    seg_s = mid_blank ? SEG_BLANK : seg_digit(mid_value % 8'd10);
      3'd1:    seg_s = seg_digit(8'd0);
      3'd0:    seg_s = seg_digit({5'd0, state_idx});
      default: seg_s = SEG_BLANK;
    endcase
  end

  // Scan divider, digit pointer (right to left) and registered display pins
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r    <= '0;
      digit_r      <= 3'd0;
      bit_select_r <= 8'hFE;
      seg_select_r <= SEG_BLANK;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
        digit_r   <= digit_r + 3'd1;
      end else begin
        div_cnt_r <= div_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      bit_select_r <= ~(8'h01 << digit_r);
      seg_select_r <= seg_s;
    end
  end

  assign bit_select = bit_select_r;
  assign seg_select = seg_select_r;

endmodule

// File: rtl/state_transitions.sv
// Vending machine controller: one-hot purchase FSM over edge-detected buttons,
// saturating money registers, and the seven-segment display scanner.
module state_transitions import vending_pkg::*; #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sys_Goods,
  input  logic       sys_Confirm,
  input  logic       sys_Change,
  input  logic       sys_Cancel,
  input  logic       in_money_one,
  input  logic       in_money_five,
  input  logic       in_money_ten,
  input  logic       in_money_twenty,
  input  logic       in_money_fifty,
  input  logic [2:0] type_SW_high,
  input  logic [2:0] type_SW_low,
  input  logic [1:0] num_SW,
  output logic [7:0] Bit_select,
  output logic [7:0] Seg_select,
  output logic [7:0] input_money_out,
  output logic [5:0] state_out,
  output logic [7:0] need_money_out,
  output logic [7:0] change_money_out
);

  logic [8:0] btn_s, prev_r, press_r;
  state_t     state_r, state_nx_s;
  logic [7:0] need_r, need_nx_s, input_r, input_nx_s, change_r, change_nx_s;
  logic [7:0] item_cost_s, coin_val_s, cart_sum_s, paid_sum_s;
  logic       ev_cancel_s, ev_change_s, ev_confirm_s, ev_goods_s, ev_coin_s;
  logic [7:0] mid_value_s;
  logic       mid_blank_s;

  assign btn_s = {sys_Cancel, sys_Change, sys_Confirm, sys_Goods, in_money_fifty,
                  in_money_twenty, in_money_ten, in_money_five, in_money_one};

  // Single winning event per cycle: Cancel > Change > Confirm > Goods > coins
  assign ev_cancel_s  = press_r[BTN_CANCEL];
  assign ev_change_s  = press_r[BTN_CHANGE] & ~press_r[BTN_CANCEL];
  assign ev_confirm_s = press_r[BTN_CONFIRM] & ~|press_r[BTN_CANCEL:BTN_CHANGE];
  assign ev_goods_s   = press_r[BTN_GOODS] & ~|press_r[BTN_CANCEL:BTN_CONFIRM];
  assign ev_coin_s    = |press_r[BTN_FIFTY:BTN_ONE] & ~|press_r[BTN_CANCEL:BTN_GOODS];

  assign item_cost_s = item_cost(type_SW_high, type_SW_low, num_SW);
  assign cart_sum_s  = sat_add(need_r, item_cost_s);
  assign paid_sum_s  = sat_add(input_r, coin_val_s);

  // Largest coin among simultaneous presses wins
  always_comb begin
    coin_val_s = 8'd0;
    if (press_r[BTN_FIFTY])       coin_val_s = COIN_FIFTY;
    else if (press_r[BTN_TWENTY]) coin_val_s = COIN_TWENTY;
    else if (press_r[BTN_TEN])    coin_val_s = COIN_TEN;
    else if (press_r[BTN_FIVE])   coin_val_s = COIN_FIVE;
    else if (press_r[BTN_ONE])    coin_val_s = COIN_ONE;
    else                          coin_val_s = 8'd0;
  end

  // Next-state and money-register update logic
  always_comb begin
    state_nx_s  = state_r;
    need_nx_s   = need_r;
    input_nx_s  = input_r;
    change_nx_s = change_r;
    case (state_r)
      ST_IDLE: begin
        if (ev_confirm_s) state_nx_s = ST_SELECT;
        else              state_nx_s = ST_IDLE;
      end
      ST_SELECT: begin
        if (ev_cancel_s) begin
          need_nx_s  = 8'd0;
          state_nx_s = ST_IDLE;
        end else if (ev_confirm_s) begin
          need_nx_s = cart_sum_s;
          if (cart_sum_s != 8'd0) state_nx_s = ST_PAY;
          else                    state_nx_s = ST_SELECT;
        end else if (ev_goods_s) begin
          need_nx_s = cart_sum_s;
        end else begin
          need_nx_s = need_r;
        end
      end
      ST_PAY, ST_PAID: begin
        if (ev_cancel_s) begin
          change_nx_s = input_r;
          state_nx_s  = ST_REFUND;
        end else if (ev_change_s && state_r == ST_PAID) begin
          change_nx_s = input_r - need_r;
          state_nx_s  = ST_CHANGE;
        end else if (ev_coin_s) begin
          input_nx_s = paid_sum_s;
          if (paid_sum_s >= need_r) state_nx_s = ST_PAID;
          else                      state_nx_s = state_r;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (ev_change_s || ev_confirm_s) begin
          need_nx_s   = 8'd0;
          input_nx_s  = 8'd0;
          change_nx_s = 8'd0;
          state_nx_s  = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        need_nx_s   = 8'd0;
        input_nx_s  = 8'd0;
        change_nx_s = 8'd0;
        state_nx_s  = ST_IDLE;
      end
    endcase
  end

  // Edge detectors and FSM/money registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      prev_r   <= 9'd0;
      press_r  <= 9'd0;
      state_r  <= ST_IDLE;
      need_r   <= 8'd0;
      input_r  <= 8'd0;
      change_r <= 8'd0;
    end else begin
      prev_r   <= btn_s;
      press_r  <= btn_s & ~prev_r;
      state_r  <= state_nx_s;
      need_r   <= need_nx_s;
      input_r  <= input_nx_s;
      change_r <= change_nx_s;
    end
  end

  // Middle display field depends on where we are in the purchase
  always_comb begin
    mid_value_s = 8'd0;
    mid_blank_s = 1'b0;
    case (state_r)
      ST_SELECT:            mid_value_s = item_cost_s;
      ST_PAY, ST_PAID:      mid_value_s = input_r;
      ST_CHANGE, ST_REFUND: mid_value_s = change_r;
      default:              mid_blank_s = 1'b1;
    endcase
  end

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
    .clk        (sys_clk),
    .rst        (sys_rst_n),
    .need       (need_r),
    .mid_value  (mid_value_s),
    .mid_blank  (mid_blank_s),
    .state_idx  (state_index(state_r)),
    .bit_select (Bit_select),
    .seg_select (Seg_select)
  );

  assign input_money_out  = input_r;
  assign state_out        = state_r;
  assign need_money_out   = need_r;
  assign change_money_out = change_r;

endmodule

// File: tb/tb_state_transitions.sv
// Self-checking bench for the vending controller: vector table through a scoreboard
// queue, plus hand-written hold, saturation, reset and display-scan sequences.
module tb_state_transitions;

  localparam logic [8:0] B_ONE    = 9'b000000001;
  localparam logic [8:0] B_FIVE   = 9'b000000010;
  localparam logic [8:0] B_TEN    = 9'b000000100;
  localparam logic [8:0] B_TWENTY = 9'b000001000;
  localparam logic [8:0] B_FIFTY  = 9'b000010000;
  localparam logic [8:0] B_GOODS  = 9'b000100000;
  localparam logic [8:0] B_CONF   = 9'b001000000;
  localparam logic [8:0] B_CHG    = 9'b010000000;
  localparam logic [8:0] B_CAN    = 9'b100000000;

  localparam logic [5:0] S_IDLE = 6'b000001, S_SEL = 6'b000010, S_PAY = 6'b000100;
  localparam logic [5:0] S_PAID = 6'b001000, S_CHG = 6'b010000, S_REF = 6'b100000;

  typedef struct {
    logic [5:0] st;
    logic [7:0] need;
    logic [7:0] inp;
    logic [7:0] chg;
  } exp_t;

  typedef struct {
    logic [8:0] btn;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [1:0] num;
    exp_t       e;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
  logic       in_money_one = 1'b0, in_money_five = 1'b0, in_money_ten = 1'b0;
  logic       in_money_twenty = 1'b0, in_money_fifty = 1'b0;
  logic [2:0] type_SW_high = 3'd0, type_SW_low = 3'd0;
  logic [1:0] num_SW = 2'd0;
  logic [7:0] Bit_select, Seg_select, input_money_out, need_money_out, change_money_out;
  logic [5:0] state_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[28];

  state_transitions #(.SCAN_DIV(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm), .sys_Change(sys_Change),
    .sys_Cancel(sys_Cancel),
    .in_money_one(in_money_one), .in_money_five(in_money_five), .in_money_ten(in_money_ten),
    .in_money_twenty(in_money_twenty), .in_money_fifty(in_money_fifty),
    .type_SW_high(type_SW_high), .type_SW_low(type_SW_low), .num_SW(num_SW),
    .Bit_select(Bit_select), .Seg_select(Seg_select),
    .input_money_out(input_money_out), .state_out(state_out),
    .need_money_out(need_money_out), .change_money_out(change_money_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive_btn(input logic [8:0] b);
    {sys_Cancel, sys_Change, sys_Confirm, sys_Goods, in_money_fifty,
     in_money_twenty, in_money_ten, in_money_five, in_money_one} = b;
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_state"},  {26'd0, state_out},        {26'd0, e.st});
      check({tag, "_need"},   {24'd0, need_money_out},   {24'd0, e.need});
      check({tag, "_input"},  {24'd0, input_money_out},  {24'd0, e.inp});
      check({tag, "_change"}, {24'd0, change_money_out}, {24'd0, e.chg});
    end
  endtask

  // One-cycle press at a negedge; result compared two edges later
  task automatic press(input logic [8:0] b, input logic [2:0] hi, input logic [2:0] lo,
                       input logic [1:0] num, input exp_t e, input string tag);
    type_SW_high = hi;
    type_SW_low  = lo;
    num_SW       = num;
    drive_btn(b);
    sb.push_back(e);
    @(negedge sys_clk);
    drive_btn(9'd0);
    @(negedge sys_clk);
    compare_front(tag);
  endtask

  function automatic vec_t mk(input logic [8:0] b, input logic [2:0] hi, input logic [2:0] lo,
                              input logic [1:0] num, input logic [5:0] st, input int need,
                              input int inp, input int chg);
    vec_t v;
    v.btn = b; v.hi = hi; v.lo = lo; v.num = num;
    v.e.st = st; v.e.need = need[7:0]; v.e.inp = inp[7:0]; v.e.chg = chg[7:0];
    return v;
  endfunction

  function automatic exp_t ex(input logic [5:0] st, input int need, input int inp, input int chg);
    exp_t e;
    e.st = st; e.need = need[7:0]; e.inp = inp[7:0]; e.chg = chg[7:0];
    return e;
  endfunction

  initial begin
    int n;
    vecs[0]  = mk(B_CONF,   3'd0, 3'd0, 2'd0, S_SEL,  0,  0,  0);
    vecs[1]  = mk(B_GOODS,  3'd2, 3'd1, 2'd3, S_SEL,  9,  0,  0);
    vecs[2]  = mk(B_CONF,   3'd3, 3'd3, 2'd1, S_PAY,  15, 0,  0);
    vecs[3]  = mk(B_ONE,    3'd3, 3'd3, 2'd1, S_PAY,  15, 1,  0);
    vecs[4]  = mk(B_FIVE,   3'd3, 3'd3, 2'd1, S_PAY,  15, 6,  0);
    vecs[5]  = mk(B_TEN,    3'd3, 3'd3, 2'd1, S_PAID, 15, 16, 0);
    vecs[6]  = mk(B_TWENTY, 3'd3, 3'd3, 2'd1, S_PAID, 15, 36, 0);
    vecs[7]  = mk(B_FIFTY,  3'd3, 3'd3, 2'd1, S_PAID, 15, 86, 0);
    vecs[8]  = mk(B_CHG,    3'd3, 3'd3, 2'd1, S_CHG,  15, 86, 71);
    vecs[9]  = mk(B_CHG,    3'd3, 3'd3, 2'd1, S_IDLE, 0,  0,  0);
    vecs[10] = mk(B_CHG,    3'd3, 3'd3, 2'd1, S_IDLE, 0,  0,  0);
    vecs[11] = mk(B_FIVE,   3'd3, 3'd3, 2'd1, S_IDLE, 0,  0,  0);
    vecs[12] = mk(B_CONF,   3'd0, 3'd0, 2'd0, S_SEL,  0,  0,  0);
    vecs[13] = mk(B_CONF,   3'd0, 3'd0, 2'd0, S_SEL,  0,  0,  0);
    vecs[14] = mk(B_GOODS,  3'd2, 3'd1, 2'd3, S_SEL,  9,  0,  0);
    vecs[15] = mk(B_CONF,   3'd3, 3'd3, 2'd1, S_PAY,  15, 0,  0);
    vecs[16] = mk(B_FIVE,   3'd3, 3'd3, 2'd1, S_PAY,  15, 5,  0);
    vecs[17] = mk(B_CAN,    3'd3, 3'd3, 2'd1, S_REF,  15, 5,  5);
    vecs[18] = mk(B_CHG,    3'd3, 3'd3, 2'd1, S_IDLE, 0,  0,  0);
    vecs[19] = mk(B_CONF,   3'd0, 3'd0, 2'd0, S_SEL,  0,  0,  0);
    vecs[20] = mk(B_CAN | B_GOODS, 3'd7, 3'd7, 2'd3, S_IDLE, 0, 0, 0);
    vecs[21] = mk(B_CONF,   3'd0, 3'd0, 2'd0, S_SEL,  0,  0,  0);
    vecs[22] = mk(B_CONF,   3'd7, 3'd7, 2'd3, S_PAY,  42, 0,  0);
    vecs[23] = mk(B_CHG,    3'd7, 3'd7, 2'd3, S_PAY,  42, 0,  0);
    vecs[24] = mk(B_FIVE | B_FIFTY, 3'd7, 3'd7, 2'd3, S_PAID, 42, 50, 0);
    vecs[25] = mk(B_TEN,    3'd7, 3'd7, 2'd3, S_PAID, 42, 60, 0);
    vecs[26] = mk(B_CAN,    3'd7, 3'd7, 2'd3, S_REF,  42, 60, 60);
    vecs[27] = mk(B_CONF,   3'd7, 3'd7, 2'd3, S_IDLE, 0,  0,  0);

    // Reset held one cycle
    @(negedge sys_clk);
    check("rst_state", {26'd0, state_out}, 32'd1);
    check("rst_need", {24'd0, need_money_out}, 32'd0);
    check("rst_input", {24'd0, input_money_out}, 32'd0);
    check("rst_change", {24'd0, change_money_out}, 32'd0);
    check("rst_bitsel", {24'd0, Bit_select}, 32'hFE);
    check("rst_seg", {24'd0, Seg_select}, 32'hFF);
    sys_rst_n = 1'b0;

    for (int i = 0; i < 28; i++)
      press(vecs[i].btn, vecs[i].hi, vecs[i].lo, vecs[i].num, vecs[i].e, $sformatf("vec%0d", i));

    // Cart total saturates at 255
    press(B_CONF, 3'd0, 3'd0, 2'd0, ex(S_SEL, 0, 0, 0), "sat_enter");
    for (int k = 1; k <= 7; k++)
      press(B_GOODS, 3'd7, 3'd7, 2'd3, ex(S_SEL, (42 * k > 255) ? 255 : 42 * k, 0, 0),
            $sformatf("sat_goods%0d", k));
    press(B_CAN, 3'd7, 3'd7, 2'd3, ex(S_IDLE, 0, 0, 0), "sat_cancel");

    // Coin held for 20 cycles counts once
    press(B_CONF, 3'd0, 3'd0, 2'd0, ex(S_SEL, 0, 0, 0), "hold_sel");
    press(B_CONF, 3'd7, 3'd7, 2'd3, ex(S_PAY, 42, 0, 0), "hold_pay");
    drive_btn(B_FIVE);
    sb.push_back(ex(S_PAY, 42, 5, 0));
    repeat (20) @(negedge sys_clk);
    drive_btn(9'd0);
    repeat (2) @(negedge sys_clk);
    compare_front("hold");

    // Reset mid-purchase
    sys_rst_n = 1'b1;
    sb.push_back(ex(S_IDLE, 0, 0, 0));
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    compare_front("midrst");

    // Display scan with need = 123 (42 + 42 + 39)
    press(B_CONF, 3'd0, 3'd0, 2'd0, ex(S_SEL, 0, 0, 0), "disp_sel");
    press(B_GOODS, 3'd7, 3'd7, 2'd3, ex(S_SEL, 42, 0, 0), "disp_g1");
    press(B_GOODS, 3'd7, 3'd7, 2'd3, ex(S_SEL, 84, 0, 0), "disp_g2");
    press(B_CONF, 3'd7, 3'd6, 2'd3, ex(S_PAY, 123, 0, 0), "disp_pay");
    n = 0;
    while (Bit_select !== 8'hEF && n < 100) begin @(negedge sys_clk); n++; end
    check("scan_find_d4", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    check("d4_seg", {24'd0, Seg_select}, 32'hC0);
    n = 0;
    while (Bit_select !== 8'hDF && n < 8) begin @(negedge sys_clk); n++; end
    check("scan_find_d5", (n < 8) ? 32'd1 : 32'd0, 32'd1);
    check("d5_seg", {24'd0, Seg_select}, 32'hB0);
    repeat (3) @(negedge sys_clk);
    check("d5_hold", {24'd0, Bit_select}, 32'hDF);
    @(negedge sys_clk);
    check("d6_bitsel", {24'd0, Bit_select}, 32'hBF);
    check("d6_seg", {24'd0, Seg_select}, 32'hA4);
    repeat (4) @(negedge sys_clk);
    check("d7_bitsel", {24'd0, Bit_select}, 32'h7F);
    check("d7_seg", {24'd0, Seg_select}, 32'hF9);
    repeat (4) @(negedge sys_clk);
    check("d0_bitsel", {24'd0, Bit_select}, 32'hFE);
    check("d0_seg", {24'd0, Seg_select}, 32'hA4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_transitions.md
Name: state_transitions

Overview:
- Main controller of the micro vending machine: one-hot FSM for goods selection, coin payment, change and refund.
- Drives an 8-digit multiplexed seven-segment display.
- Sits between the board buttons/switches (pre-synchronised, possibly multi-cycle) and the display pins.
- Exposes internal money registers and state for debug and verification.

Parameters:
- SCAN_DIV, 100000, sys_clk cycles per display digit (1 kHz at 100 MHz); benches may override to 4.

Ports:
- sys_clk  in  1  single system clock, all logic on rising edge
- sys_rst_n  in  1  synchronous, active-high reset (name kept as in the codebase; high = reset)
- sys_Goods  in  1  button: add current selection to cart
- sys_Confirm  in  1  button: start purchase / finish selection
- sys_Change  in  1  button: request change / acknowledge
- sys_Cancel  in  1  button: abort
- in_money_one, in_money_five, in_money_ten, in_money_twenty, in_money_fifty  in  1 each  coin/note buttons worth 1/5/10/20/50
- type_SW_high  in  3  goods row
- type_SW_low  in  3  goods column
- num_SW  in  2  quantity 0..3
- Bit_select  out  8  digit enable, one-hot active-low, bit7 = leftmost
- Seg_select  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- input_money_out  out  8  money inserted
- state_out  out  6  current one-hot state
- need_money_out  out  8  cart total
- change_money_out  out  8  change/refund amount

Behaviour:
- Every button has a registered rising-edge detector (in & ~prev). A press acts exactly once however long it is held. Its effect is visible on outputs after the 2nd rising edge where the input is sampled high.
- Reset: state = IDLE; need, input, change = 0; edge registers cleared; scan counter = 0; Bit_select = 8'hFE; Seg_select = 8'hFF.
- unit_price = type_SW_high + type_SW_low (0..14). item_cost = unit_price * num_SW.
- All money sums saturate at 255.
- States (one-hot): IDLE=000001, SELECT=000010, PAY=000100, PAID=001000, CHANGE=010000, REFUND=100000.
- IDLE: Confirm -> SELECT. Other inputs ignored.
- SELECT:
  - Goods: need += item_cost.
  - Confirm: need += item_cost; then -> PAY if the new need > 0, else stay in SELECT.
  - Cancel: need = 0 -> IDLE.
- PAY:
  - Coin press: input += value.
  - When input >= need, transition to PAID on the same edge the coin is accumulated.
  - Cancel: change = input -> REFUND.
  - Change ignored.
- PAID:
  - Coins still accumulate.
  - Change: change = input - need -> CHANGE.
  - Cancel: change = input -> REFUND.
- CHANGE / REFUND: Change or Confirm press clears need, input and change, then -> IDLE.
- Simultaneous presses, priority: Cancel > Change > Confirm > Goods > coins. Among coins the largest wins; the others are dropped.
- Coins outside PAY/PAID are ignored. Switch changes alone cause no action.
- Reset mid-purchase returns everything to reset values on the next edge.
- Display scan: counter advances one digit every SCAN_DIV cycles, right to left, wrapping.
  - Digits 7..5: need, 3-digit decimal.
  - Digits 4..2: input in PAY/PAID; change in CHANGE/REFUND; current item_cost in SELECT; blank in IDLE.
  - Digits 1..0: state index 0..5 as decimal "0n".
  - Blank = 8'hFF. Decimal points off.
- *_money_out and state_out are the registers themselves, with no extra latency.

Decomposition:
- Package vending_pkg: state encodings, coin value constants, price function, 7-seg digit LUT.
- One sub-module seg_scan: SCAN_DIV counter, digit mux, binary-to-BCD, segment decode.

Test Plan:
- Reset held 1 cycle -> state_out=000001; need, input, change = 0; Bit_select=FE.
- Confirm; set (2,1,3); Goods; set (3,3,1); Confirm -> need 9 after Goods, then 15; state PAY.
- Coins 1,5,10 -> input 1,6,16; state PAID after the 10. Then 20,50 -> input 86.
- Change -> CHANGE, change=71. Change -> IDLE with all zero. Further Change presses -> no effect.
- In PAY with need 15: insert 5, Cancel -> REFUND, change=5. Change -> IDLE.
- Button held 20 cycles in PAY (five) -> input increases by exactly 5.
- Set SCAN_DIV=4 and need=123 -> digits 7..5 show 1,2,3, one digit every 4 cycles.
